ste_dma_audio: RTL and testbench

Parametrised STE/Falcon-class DMA sound playback engine: accepts 16-bit words strobed in by the MCU's sound-load cycle, buffers them in a count-based FIFO, and plays them out at a selectable sample rate as left/right offset-binary samples. It generalises the shifter's built-in 8-bit DMA sound path with configurable depth and output width. It adds optional 16-bit stereo, full-depth FIFO use, overflow/underrun status and flush. It sits beside the shifter on clk32, fed by `SLOAD_N`/`MDIN` and driving the audio mixer.

---
 rtl/dma_audio_pkg.sv | 25 ++
 rtl/audio_fifo.sv | 83 ++++++++
 rtl/ste_dma_audio.sv | 211 +++++++++++++++++++++
 tb/tb_ste_dma_audio.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_audio_pkg.sv
// -----------------------------------------------------------------------------
// dma_audio_pkg
// Shared constants and helpers for the STE/Falcon-class DMA sound engine.
//   RATE_*      : codes for mode[1:0] (playback rate select)
//   MODE_MONO   : mode bit index selecting 8-bit mono unpacking
//   MODE_W16    : mode bit index selecting 16-bit stereo unpacking
//   s8_to_out() : signed 8-bit sample -> left-justified 16-bit offset binary
// -----------------------------------------------------------------------------
package dma_audio_pkg;

  localparam logic [1:0] RATE_50K  = 2'b11;
  localparam logic [1:0] RATE_25K  = 2'b10;
  localparam logic [1:0] RATE_12K5 = 2'b01;
  localparam logic [1:0] RATE_6K25 = 2'b00;

  localparam int MODE_MONO = 2;
  localparam int MODE_W16  = 3;

  // Inverting the sign bit turns two's complement into offset binary; the
  // byte sits in the top half so callers can keep the top OUT_W bits.
  function automatic logic [15:0] s8_to_out(input logic [7:0] b);
    return {~b[7], b[6:0], 8'h00};
  endfunction

endpackage

// File: rtl/audio_fifo.sv
// -----------------------------------------------------------------------------
// audio_fifo
// Count-based synchronous FIFO; all 2^ADDR_BITS entries are usable.
// Ports:
//   clk32, resb   : clock, asynchronous active-low reset
//   i_wr, i_wdata : write request and data (dropped when full and not popping)
//   i_pop         : number of words to pop this cycle (0..2, caller ensures
//                   that at least that many words are present)
//   i_flush       : clears pointers and count; a same-cycle write is discarded
//   o_rdata0/1    : head word and the word behind it (combinational reads)
//   o_level       : current word count
//   o_full        : level == depth
//   o_wr_drop     : a write was rejected because the FIFO was full
// -----------------------------------------------------------------------------
module audio_fifo #(
  parameter int ADDR_BITS = 3,
  parameter int DATA_W    = 16
) (
  input  logic                 clk32,
  input  logic                 resb,
  input  logic                 i_wr,
  input  logic [DATA_W-1:0]    i_wdata,
  input  logic [1:0]           i_pop,
  input  logic                 i_flush,
  output logic [DATA_W-1:0]    o_rdata0,
  output logic [DATA_W-1:0]    o_rdata1,
  output logic [ADDR_BITS:0]   o_level,
  output logic                 o_full,
  output logic                 o_wr_drop
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS:0] LVL_FULL = (ADDR_BITS+1)'(DEPTH);

  logic [DATA_W-1:0]    r_mem [DEPTH];
  logic [ADDR_BITS-1:0] r_wr_ptr;
  logic [ADDR_BITS-1:0] r_rd_ptr;
  logic [ADDR_BITS:0]   r_level;

  logic                 w_full;
  logic                 w_popping;
  logic                 w_wr_acc;
  logic [ADDR_BITS-1:0] w_rd_ptr1;

  assign w_full    = (r_level == LVL_FULL);
  assign w_popping = (i_pop != 2'd0);
  // A pop frees the head slot before the edge, so a full FIFO can still take
  // a word in the same cycle; when full, rd_ptr == wr_ptr and the read of the
  // head happens combinationally ahead of the overwrite.
  assign w_wr_acc  = i_wr & ~i_flush & (~w_full | w_popping);
  assign o_wr_drop = i_wr & ~i_flush & w_full & ~w_popping;
  assign w_rd_ptr1 = r_rd_ptr + ADDR_BITS'(1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation order cannot change the result.
  always_ff @(posedge clk32 or negedge resb) begin
    if (!resb) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + ADDR_BITS'(1);
      r_rd_ptr <= r_rd_ptr + ADDR_BITS'(i_pop);
      r_level  <= r_level + (ADDR_BITS+1)'(w_wr_acc) - (ADDR_BITS+1)'(i_pop);
    end
  end

  // NOTE: the storage array has no reset; pointers and count define which
  // entries are valid, and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clk32) begin
    if (w_wr_acc) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata0 = r_mem[r_rd_ptr];
  assign o_rdata1 = r_mem[w_rd_ptr1];
  assign o_level  = r_level;
  assign o_full   = w_full;

endmodule

// File: rtl/ste_dma_audio.sv
// -----------------------------------------------------------------------------
// ste_dma_audio
// DMA sound playback engine: 16-bit words strobed in by SLOAD_N are buffered
// in audio_fifo and played out at a selectable rate as offset-binary samples.
// Optional feature macro: DMA_AUDIO_16BIT_EN (enables mode[3] 16-bit stereo;
// when undefined mode[3] is ignored and at most one word is popped per tick).
// Ports:
//   clk32, resb              : clock, asynchronous active-low reset
//   mode[3:0]                : [1:0] rate, [2] 8-bit mono, [3] 16-bit stereo
//   flush                    : synchronous FIFO and byte-select clear
//   clr_status               : clears sticky ovf/udf (set events win)
//   SLOAD_N, MDIN            : load strobe (falling edge writes) and data
//   SREQ                     : high while the FIFO is not full
//   audio_left, audio_right  : offset-binary samples, midscale after reset
//   samp_stb                 : one-cycle pulse when the outputs update
//   level                    : FIFO word count
//   ovf, udf                 : sticky overflow / underrun flags
// -----------------------------------------------------------------------------
module ste_dma_audio
  import dma_audio_pkg::*;
#(
  parameter int FIFO_ADDR_BITS = 3,
  parameter int OUT_W          = 8,
  parameter int CLK_DIV        = 640
) (
  input  logic                      clk32,
  input  logic                      resb,
  input  logic [3:0]                mode,
  input  logic                      flush,
  input  logic                      clr_status,
  input  logic                      SLOAD_N,
  input  logic [15:0]               MDIN,
  output logic                      SREQ,
  output logic [OUT_W-1:0]          audio_left,
  output logic [OUT_W-1:0]          audio_right,
  output logic                      samp_stb,
  output logic [FIFO_ADDR_BITS:0]   level,
  output logic                      ovf,
  output logic                      udf
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [OUT_W-1:0] MIDSCALE = OUT_W'(1) << (OUT_W - 1);

  // ---------------------------------------------------------------- write path
  logic                    r_sload_d;
  logic                    w_wr;
  logic [1:0]              w_pop;
  logic [15:0]             w_rd0;
  logic [15:0]             w_rd1;
  logic                    w_full;
  logic                    w_wr_drop;

  assign w_wr = r_sload_d & ~SLOAD_N;

  audio_fifo #(
    .ADDR_BITS (FIFO_ADDR_BITS),
    .DATA_W    (16)
  ) u_fifo (
    .clk32     (clk32),
    .resb      (resb),
    .i_wr      (w_wr),
    .i_wdata   (MDIN),
    .i_pop     (w_pop),
    .i_flush   (flush),
    .o_rdata0  (w_rd0),
    .o_rdata1  (w_rd1),
    .o_level   (level),
    .o_full    (w_full),
    .o_wr_drop (w_wr_drop)
  );

  assign SREQ = ~w_full;

  // ------------------------------------------------------------ rate generator
  logic [DIV_W-1:0] r_base;
  logic [2:0]       r_pre;
  logic             w_btick;
  logic             w_rate_hit;
  logic             w_stick;

  assign w_btick = (r_base == DIV_W'(CLK_DIV - 1));

  // Rate is decoded from the live mode bits, so a change lands on the next
  // tick boundary and never cuts a period short.
  always_comb begin
    w_rate_hit = 1'b0;
    unique case (mode[1:0])
      RATE_50K:  w_rate_hit = 1'b1;
      RATE_25K:  w_rate_hit = ~r_pre[0];
      RATE_12K5: w_rate_hit = (r_pre[1:0] == 2'd0);
      RATE_6K25: w_rate_hit = (r_pre == 3'd0);
    endcase
  end

  assign w_stick = w_btick & w_rate_hit;

  // ------------------------------------------------------------------ unpacker
  logic                    w_w16;
  logic [1:0]              w_mode_bits;
  logic [1:0]              r_mode_bits;
  logic                    w_mode_chg;
  logic                    r_bytesel;
  logic                    w_bytesel_nxt;
  logic [OUT_W-1:0]        r_left;
  logic [OUT_W-1:0]        r_right;
  logic [OUT_W-1:0]        w_left_nxt;
  logic [OUT_W-1:0]        w_right_nxt;
  logic                    r_stb;
  logic                    w_stb_nxt;
  logic                    w_udf_set;
  logic [15:0]             w_hi_out;
  logic [15:0]             w_lo_out;
  logic [15:0]             w_mono_out;

`ifdef DMA_AUDIO_16BIT_EN
  logic [15:0] w_l16_out;
  logic [15:0] w_r16_out;
  assign w_w16     = mode[MODE_W16];
  assign w_l16_out = w_rd0 ^ 16'h8000;
  assign w_r16_out = w_rd1 ^ 16'h8000;
`else
  logic w_unused_bits;
  assign w_w16         = 1'b0;
  assign w_unused_bits = ^{mode[MODE_W16], w_rd1};
`endif

  assign w_mode_bits = {w_w16, mode[MODE_MONO]};
  assign w_mode_chg  = (w_mode_bits != r_mode_bits);
  assign w_hi_out    = s8_to_out(w_rd0[15:8]);
  assign w_lo_out    = s8_to_out(w_rd0[7:0]);
  assign w_mono_out  = r_bytesel ? w_lo_out : w_hi_out;

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_pop         = 2'd0;
    w_stb_nxt     = 1'b0;
    w_udf_set     = 1'b0;
    w_left_nxt    = r_left;
    w_right_nxt   = r_right;
    w_bytesel_nxt = r_bytesel;

    // Flush holds outputs and flags, so a coincident tick is ignored.
    if (w_stick && !flush) begin
`ifdef DMA_AUDIO_16BIT_EN
      if (w_w16) begin
        // A lone word stays queued until its right-channel partner arrives.
        if (level >= (FIFO_ADDR_BITS+1)'(2)) begin
          w_left_nxt  = w_l16_out[15 -: OUT_W];
          w_right_nxt = w_r16_out[15 -: OUT_W];
          w_pop       = 2'd2;
          w_stb_nxt   = 1'b1;
        end else begin
          w_udf_set   = 1'b1;
        end
      end else
`endif
      if (level == '0) begin
        w_udf_set = 1'b1;
      end else if (mode[MODE_MONO]) begin
        w_left_nxt    = w_mono_out[15 -: OUT_W];
        w_right_nxt   = w_mono_out[15 -: OUT_W];
        w_pop         = {1'b0, r_bytesel};
        w_bytesel_nxt = ~r_bytesel;
        w_stb_nxt     = 1'b1;
      end else begin
        w_left_nxt  = w_hi_out[15 -: OUT_W];
        w_right_nxt = w_lo_out[15 -: OUT_W];
        w_pop       = 2'd1;
        w_stb_nxt   = 1'b1;
      end
    end

    if (flush || w_mode_chg) w_bytesel_nxt = 1'b0;
  end

  // ------------------------------------------------------------- state update
  always_ff @(posedge clk32 or negedge resb) begin
    if (!resb) begin
      r_sload_d   <= 1'b1;
      r_base      <= '0;
      r_pre       <= '0;
      r_mode_bits <= '0;
      r_bytesel   <= 1'b0;
      r_left      <= MIDSCALE;
      r_right     <= MIDSCALE;
      r_stb       <= 1'b0;
      ovf         <= 1'b0;
      udf         <= 1'b0;
    end else begin
      r_sload_d   <= SLOAD_N;
      r_base      <= w_btick ? '0 : r_base + DIV_W'(1);
      if (w_btick) r_pre <= r_pre + 3'd1;
      r_mode_bits <= w_mode_bits;
      r_bytesel   <= w_bytesel_nxt;
      r_left      <= w_left_nxt;
      r_right     <= w_right_nxt;
      r_stb       <= w_stb_nxt;
      if (w_wr_drop)       ovf <= 1'b1;
      else if (clr_status) ovf <= 1'b0;
      if (w_udf_set)       udf <= 1'b1;
      else if (clr_status) udf <= 1'b0;
    end
  end

  assign audio_left  = r_left;
  assign audio_right = r_right;
  assign samp_stb    = r_stb;

endmodule

// File: tb/tb_ste_dma_audio.sv
// -----------------------------------------------------------------------------
// tb_ste_dma_audio
// Directed bench for ste_dma_audio (depth 8, CLK_DIV 640). With
// DMA_AUDIO_16BIT_EN defined it builds OUT_W=16 and exercises 16-bit stereo;
// otherwise OUT_W=8 and it confirms mode[3] is ignored.
// -----------------------------------------------------------------------------
module tb_ste_dma_audio;

`ifdef DMA_AUDIO_16BIT_EN
  localparam int OUT_W = 16;
`else
  localparam int OUT_W = 8;
`endif
  localparam int AB = 3;

  logic              clk32 = 1'b0;
  logic              resb;
  logic [3:0]        mode;
  logic              flush;
  logic              clr_status;
  logic              SLOAD_N;
  logic [15:0]       MDIN;
  logic              SREQ;
  logic [OUT_W-1:0]  audio_left;
  logic [OUT_W-1:0]  audio_right;
  logic              samp_stb;
  logic [AB:0]       level;
  logic              ovf;
  logic              udf;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk32 = ~clk32;

  ste_dma_audio #(
    .FIFO_ADDR_BITS (AB),
    .OUT_W          (OUT_W),
    .CLK_DIV        (640)
  ) dut (
    .clk32       (clk32),
    .resb        (resb),
    .mode        (mode),
    .flush       (flush),
    .clr_status  (clr_status),
    .SLOAD_N     (SLOAD_N),
    .MDIN        (MDIN),
    .SREQ        (SREQ),
    .audio_left  (audio_left),
    .audio_right (audio_right),
    .samp_stb    (samp_stb),
    .level       (level),
    .ovf         (ovf),
    .udf         (udf)
  );

  // 8-bit offset-binary code left-justified to OUT_W.
  function automatic logic [OUT_W-1:0] ex8(input logic [7:0] v);
    logic [15:0] t;
    t = {v, 8'h00};
    return t[15 -: OUT_W];
  endfunction

  function automatic logic [OUT_W-1:0] ex16(input logic [15:0] v);
    return v[15 -: OUT_W];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk32);
    #1;
  endtask

  task automatic write_word(input logic [15:0] w);
    SLOAD_N = 1'b0;
    MDIN    = w;
    step();
    SLOAD_N = 1'b1;
    step();
  endtask

  task automatic pulse_clr();
    clr_status = 1'b1;
    step();
    clr_status = 1'b0;
  endtask

  task automatic wait_stb(input int max, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (samp_stb !== 1'b1 && n < max);
  endtask

  task automatic wait_udf(input int max, output int n, output bit stb_seen);
    n = 0;
    stb_seen = 1'b0;
    do begin
      step();
      n++;
      if (samp_stb === 1'b1) stb_seen = 1'b1;
    end while (udf !== 1'b1 && n < max);
  endtask

  initial begin
    int  n;
    bit  seen;
    logic [7:0] b;

    resb       = 1'b0;
    mode       = 4'b0011;
    flush      = 1'b0;
    clr_status = 1'b0;
    SLOAD_N    = 1'b1;
    MDIN       = 16'h0000;
    repeat (3) step();

    check("rst_left",  audio_left,  ex8(8'h80));
    check("rst_right", audio_right, ex8(8'h80));
    check("rst_sreq",  SREQ,     1'b1);
    check("rst_level", level,    0);
    check("rst_stb",   samp_stb, 1'b0);
    check("rst_ovf",   ovf,      1'b0);
    check("rst_udf",   udf,      1'b0);
    resb = 1'b1;

    // Idle: first tick underruns without a strobe.
    wait_udf(700, n, seen);
    check("idle_udf",      udf,  1'b1);
    check("idle_no_stb",   seen, 1'b0);
    check("idle_left",     audio_left, ex8(8'h80));
    pulse_clr();
    check("idle_udf_clr",  udf,  1'b0);

    // Stereo 8-bit, 50 kHz.
    write_word(16'h7F80);
    check("st_level_wr", level, 1);
    wait_stb(700, n);
    check("st_stb1",   samp_stb, 1'b1);
    check("st_left1",  audio_left,  ex8(8'hFF));
    check("st_right1", audio_right, ex8(8'h00));
    check("st_level1", level, 0);
    write_word(16'h0102);
    wait_stb(700, n);
    check("st_spacing", n + 2, 640);
    check("st_left2",  audio_left,  ex8(8'h81));
    check("st_right2", audio_right, ex8(8'h82));
    check("st_udf",    udf, 1'b0);

    // Mono 8-bit, 12.5 kHz: high byte then low byte, one pop.
    mode = 4'b0101;
    write_word(16'h0102);
    wait_stb(3000, n);
    check("mono_stb1",   samp_stb, 1'b1);
    check("mono_left1",  audio_left,  ex8(8'h81));
    check("mono_right1", audio_right, ex8(8'h81));
    check("mono_level1", level, 1);
    wait_stb(3000, n);
    check("mono_spacing", n, 2560);
    check("mono_left2",  audio_left,  ex8(8'h82));
    check("mono_right2", audio_right, ex8(8'h82));
    check("mono_level2", level, 0);
    check("mono_udf0",   udf, 1'b0);
    wait_udf(3000, n, seen);
    check("mono_udf1",   udf, 1'b1);
    check("mono_nostb",  seen, 1'b0);
    check("mono_hold",   audio_left, ex8(8'h82));

    // Overflow at 6.25 kHz, right after a tick so no pop intervenes.
    mode = 4'b0000;
    pulse_clr();
    wait_udf(6000, n, seen);
    check("ovf_sync_udf", udf, 1'b1);
    pulse_clr();
    check("ovf_udf_clr", udf, 1'b0);
    for (int i = 0; i < 8; i++) begin
      b = 8'h10 + 8'(i);
      write_word({b, b + 8'h10});
      if (i == 6) check("ovf_sreq_7", SREQ, 1'b1);
    end
    check("ovf_level8", level, 8);
    check("ovf_sreq8",  SREQ,  1'b0);
    check("ovf_flag0",  ovf,   1'b0);
    write_word(16'h1828);
    check("ovf_level9", level, 8);
    check("ovf_flag1",  ovf,   1'b1);
    pulse_clr();
    check("ovf_clr",    ovf,   1'b0);

    // 50 kHz drain, then a write landing on the same edge as a pop at full.
    mode = 4'b0011;
    wait_stb(700, n);
    check("sim_left0",  audio_left,  ex8(8'h90));
    check("sim_right0", audio_right, ex8(8'hA0));
    check("sim_level7", level, 7);
    write_word(16'h5566);
    check("sim_level8", level, 8);
    repeat (637) step();
    SLOAD_N = 1'b0;
    MDIN    = 16'hABCD;
    step();
    SLOAD_N = 1'b1;
    check("sim_stb",    samp_stb, 1'b1);
    check("sim_level",  level, 8);
    check("sim_ovf",    ovf, 1'b0);
    check("sim_left",   audio_left,  ex8(8'h91));
    check("sim_right",  audio_right, ex8(8'hA1));

    // Drain to level 5, then flush with a coincident write.
    for (int i = 0; i < 3; i++) wait_stb(700, n);
    check("fl_level5", level, 5);
    check("fl_left5",  audio_left,  ex8(8'h94));
    flush   = 1'b1;
    SLOAD_N = 1'b0;
    MDIN    = 16'hEEEE;
    step();
    flush   = 1'b0;
    SLOAD_N = 1'b1;
    check("fl_level0", level, 0);
    check("fl_left",   audio_left,  ex8(8'h94));
    check("fl_right",  audio_right, ex8(8'hA4));
    check("fl_sreq",   SREQ, 1'b1);
    step();
    check("fl_wr_drop", level, 0);
    wait_udf(700, n, seen);
    check("fl_udf",     udf, 1'b1);
    check("fl_hold",    audio_left, ex8(8'h94));

    // Asynchronous reset mid-operation.
    write_word(16'h1234);
    check("ar_level1", level, 1);
    #2 resb = 1'b0;
    #1;
    check("ar_level0", level, 0);
    check("ar_left",   audio_left, ex8(8'h80));
    check("ar_udf",    udf, 1'b0);
    step();
    resb = 1'b1;

    mode = 4'b1011;
`ifdef DMA_AUDIO_16BIT_EN
    write_word(16'h8000);
    wait_udf(700, n, seen);
    check("w16_udf",    udf, 1'b1);
    check("w16_nostb",  seen, 1'b0);
    check("w16_kept",   level, 1);
    check("w16_hold",   audio_left, ex8(8'h80));
    write_word(16'h7FFF);
    wait_stb(700, n);
    check("w16_stb",    samp_stb, 1'b1);
    check("w16_left",   audio_left,  ex16(16'h0000));
    check("w16_right",  audio_right, ex16(16'hFFFF));
    check("w16_level",  level, 0);
`else
    write_word(16'h7F80);
    wait_stb(700, n);
    check("m3_stb",     samp_stb, 1'b1);
    check("m3_left",    audio_left,  ex8(8'hFF));
    check("m3_right",   audio_right, ex8(8'h00));
    check("m3_level",   level, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
